// File: rtl/four_input_gate_test_sequencer_pkg.sv
// Shared types and widths for the four-input gate test sequencer.
// Imported by the interface, the settle timer and the top.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    localparam int PATTERN_W    = 4;
    localparam int NUM_PATTERNS = 16;
    localparam int CNT_W        = 4;
    localparam int ERR_W        = 5;

endpackage

// File: rtl/four_input_gate_test_sequencer_if.sv
// Board-side bundle: start button, gate stimulus/response, result LEDs.
// The sequencer is the master; board logic and the gate form the slave.
interface four_input_gate_test_sequencer_if;
    import gate_test_pkg::*;

    logic                 start;
    logic                 a;
    logic                 b;
    logic                 c;
    logic                 d;
    logic                 e;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_W-1:0]     err_count;
    logic                 fail_valid;
    logic [PATTERN_W-1:0] first_fail_idx;

    modport master (
        input  start,
        input  e,
        output a,
        output b,
        output c,
        output d,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_valid,
        output first_fail_idx
    );

    modport slave (
        output start,
        output e,
        input  a,
        input  b,
        input  c,
        input  d,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_valid,
        input  first_fail_idx
    );

endinterface

// File: rtl/four_input_gate_test_sequencer_settle_timer.sv
// Per-pattern hold counter; expire marks the sample cycle of a pattern.
// The count wraps to zero on expiry so patterns chain without a gap.
module settle_timer
    import gate_test_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] settle_cycles,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    assign expire = enable && (cnt == settle_cycles);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/four_input_gate_test_sequencer.sv
// Exhaustive 16-pattern sweep of a 4-input gate with truth-table check.
// Drives {a,b,c,d}=idx, samples e at the end of each settle window.
module four_input_gate_test_sequencer
    import gate_test_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] TRUTH_TABLE   = 16'h0001
) (
    input  logic                           clk,
    input  logic                           rst,
    four_input_gate_test_sequencer_if.master bus
);

    localparam logic [PATTERN_W-1:0] LAST_IDX =
        PATTERN_W'(NUM_PATTERNS - 1);

    state_t               state;
    logic [PATTERN_W-1:0] idx;
    logic [PATTERN_W-1:0] pat;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [ERR_W-1:0]     err_q;
    logic                 fail_valid_q;
    logic [PATTERN_W-1:0] first_fail_q;

    logic                 expire;
    logic                 timer_clear;
    logic                 timer_en;
    logic                 mismatch;
    logic [ERR_W-1:0]     err_next;

    assign timer_en    = (state == DRIVE);
    assign timer_clear = (state != DRIVE) && bus.start;
    assign mismatch    = (bus.e != TRUTH_TABLE[idx]);
    assign err_next    = err_q + {{(ERR_W-1){1'b0}}, mismatch};

    settle_timer u_timer (
        .clk           (clk),
        .rst           (rst),
        .clear         (timer_clear),
        .enable        (timer_en),
        .settle_cycles (CNT_W'(SETTLE_CYCLES)),
        .expire        (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            pat          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state        <= DRIVE;
                        idx          <= '0;
                        pat          <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                    end
                end
                DRIVE: begin
                    if (expire) begin
                        err_q <= err_next;
                        if (mismatch && !fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            first_fail_q <= idx;
                        end
                        // pass is judged on the final count, including this sample
                        if (idx == LAST_IDX) begin
                            state  <= DONE;
                            pat    <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (err_next == '0);
                        end else begin
                            idx <= idx + 1'b1;
                            pat <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a              = pat[3];
    assign bus.b              = pat[2];
    assign bus.c              = pat[1];
    assign bus.d              = pat[0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.fail_valid     = fail_valid_q;
    assign bus.first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_four_input_gate_test_sequencer.sv
// Scoreboarded bench: three sequencer configurations, behavioural gates,
// expected sweep results queued at start and checked when done rises.
module tb_four_input_gate_test_sequencer;

    typedef struct {
        int err;
        int ffi;
        int fv;
        int pass;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_r;
    logic [2:0]  start_r;
    logic [2:0]  busy_w;
    logic [2:0]  done_w;
    int          mode_r [3];
    logic [15:0] rtab_r [3];
    exp_t        exp_q [3][$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    function automatic int settle_of(int g);
        return (g == 2) ? 0 : 2;
    endfunction

    function automatic logic [15:0] tt_of(int g);
        return (g == 1) ? 16'h8000 : 16'h0001;
    endfunction

    // 0: NOR, 1: AND, 2: stuck-at-0, other: arbitrary table
    function automatic logic gate_fn(int mode, logic [15:0] tab,
                                     logic [3:0] p);
        case (mode)
            0:       return ~(p[3] | p[2] | p[1] | p[0]);
            1:       return p[3] & p[2] & p[1] & p[0];
            2:       return 1'b0;
            default: return tab[p];
        endcase
    endfunction

    function automatic exp_t model(int g);
        exp_t        x;
        logic [15:0] tt;
        tt    = tt_of(g);
        x.err = 0;
        x.ffi = 0;
        for (int i = 0; i < 16; i++) begin
            if (gate_fn(mode_r[g], rtab_r[g], 4'(i)) != tt[i]) begin
                if (x.err == 0) x.ffi = i;
                x.err++;
            end
        end
        x.fv   = (x.err != 0) ? 1 : 0;
        x.pass = (x.err == 0) ? 1 : 0;
        return x;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int          S  = (g == 2) ? 0 : 2;
        localparam logic [15:0] TT = (g == 1) ? 16'h8000 : 16'h0001;

        four_input_gate_test_sequencer_if bus ();

        four_input_gate_test_sequencer #(
            .SETTLE_CYCLES (S),
            .TRUTH_TABLE   (TT)
        ) dut (
            .clk (clk),
            .rst (rst_r[g]),
            .bus (bus)
        );

        assign bus.start = start_r[g];
        assign bus.e     = gate_fn(mode_r[g], rtab_r[g],
                                   {bus.a, bus.b, bus.c, bus.d});
        assign busy_w[g] = bus.busy;
        assign done_w[g] = bus.done;

        int   cyc = 0;
        logic dq  = 1'b0;

        always @(negedge clk) begin
            exp_t x;
            if (rst_r[g]) begin
                cyc = 0;
                dq  = 1'b0;
            end else begin
                if (bus.busy) begin
                    check($sformatf("u%0d_pattern", g),
                          int'({bus.a, bus.b, bus.c, bus.d}), cyc / (S + 1));
                    cyc++;
                end else begin
                    check($sformatf("u%0d_idle_pattern", g),
                          int'({bus.a, bus.b, bus.c, bus.d}), 0);
                end
                if (bus.done && !dq) begin
                    check($sformatf("u%0d_sweep_len", g), cyc, 16 * (S + 1));
                    if (exp_q[g].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL u%0d_unexpected_done: got done expected none", g);
                    end else begin
                        x = exp_q[g].pop_front();
                        check($sformatf("u%0d_err_count", g),
                              int'(bus.err_count), x.err);
                        check($sformatf("u%0d_fail_valid", g),
                              int'(bus.fail_valid), x.fv);
                        check($sformatf("u%0d_first_fail_idx", g),
                              int'(bus.first_fail_idx), x.ffi);
                        check($sformatf("u%0d_pass", g),
                              int'(bus.pass), x.pass);
                        check($sformatf("u%0d_busy_in_done", g),
                              int'(bus.busy), 0);
                    end
                    cyc = 0;
                end
                dq = bus.done;
            end
        end
    end

    task automatic pulse_start(int g, bit expect_run);
        @(negedge clk);
        if (expect_run) exp_q[g].push_back(model(g));
        start_r[g] = 1'b1;
        @(negedge clk);
        start_r[g] = 1'b0;
    endtask

    task automatic wait_done(int g);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_w[g]) return;
        end
        checks++;
        failures++;
        $display("FAIL u%0d_done_timeout: got done=0 expected done=1", g);
    endtask

    task automatic run(int g, int mode);
        mode_r[g] = mode;
        pulse_start(g, 1'b1);
        wait_done(g);
    endtask

    initial begin
        int n;
        int g;
        rst_r   = 3'b111;
        start_r = 3'b000;
        for (int i = 0; i < 3; i++) begin
            mode_r[i] = 0;
            rtab_r[i] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        check("rst_abcd", int'({u[0].bus.a, u[0].bus.b,
                                u[0].bus.c, u[0].bus.d}), 0);
        check("rst_busy", int'(u[0].bus.busy), 0);
        check("rst_done", int'(u[0].bus.done), 0);
        check("rst_pass", int'(u[0].bus.pass), 0);
        check("rst_err_count", int'(u[0].bus.err_count), 0);
        check("rst_fail_valid", int'(u[0].bus.fail_valid), 0);
        check("rst_first_fail", int'(u[0].bus.first_fail_idx), 0);
        rst_r = 3'b000;

        run(0, 0);
        run(0, 2);
        run(0, 1);
        run(1, 1);

        // reset in the middle of a sweep
        mode_r[0] = 3;
        rtab_r[0] = 16'($urandom);
        pulse_start(0, 1'b1);
        n = 1;
        for (int i = 0; i < 200 && n < 20; i++) begin
            @(negedge clk);
            if (busy_w[0]) n++;
        end
        #1 rst_r[0] = 1'b1;
        #1;
        check("midrst_abcd", int'({u[0].bus.a, u[0].bus.b,
                                   u[0].bus.c, u[0].bus.d}), 0);
        check("midrst_busy", int'(u[0].bus.busy), 0);
        check("midrst_err_count", int'(u[0].bus.err_count), 0);
        check("midrst_fail_valid", int'(u[0].bus.fail_valid), 0);
        exp_q[0].delete();
        repeat (2) @(negedge clk);
        rst_r[0] = 1'b0;

        // start while sweeping must be ignored
        mode_r[0] = 0;
        pulse_start(0, 1'b1);
        repeat ($urandom_range(3, 30)) @(negedge clk);
        pulse_start(0, 1'b0);
        wait_done(0);

        // zero settle, then restart out of DONE
        run(2, 0);
        pulse_start(2, 1'b1);
        check("restart_done_low", int'(done_w[2]), 0);
        check("restart_busy_high", int'(busy_w[2]), 1);
        check("restart_err_cleared", int'(u[2].bus.err_count), 0);
        wait_done(2);

        for (int k = 0; k < 8; k++) begin
            g = int'($urandom_range(0, 2));
            rtab_r[g] = 16'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run(g, int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_queue_empty", i), exp_q[i].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
